// File: rtl/pc_call_stack.sv
// Program counter with an integrated LIFO return-address stack for call/return.
// Sticky overflow/underflow flags record bad calls and returns until reset.
module pc_call_stack #(
  parameter int unsigned        ADDR_W       = 8,
  parameter int unsigned        STACK_DEPTH  = 4,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input  logic                             i_Timming,
  input  logic                             i_Rst,
  input  logic                             i_Enable,
  input  logic                             i_Senal_de_salto,
  input  logic [ADDR_W-1:0]                i_Direccion_salto,
  input  logic                             i_Call,
  input  logic                             i_Return,
  output logic [ADDR_W-1:0]                o_Fetch,
  output logic [ADDR_W-1:0]                o_Stack,
  output logic [$clog2(STACK_DEPTH+1)-1:0] o_Stack_Nivel,
  output logic                             o_Overflow,
  output logic                             o_Underflow
);

  localparam int unsigned LW = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] top;
  logic              empty, full;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign empty  = (level_q == '0);
  assign full   = (level_q == LW'(STACK_DEPTH));

  // Top entry lives at slot level-1; reads as zero when the stack is empty.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (level_q == LW'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    stack_d = stack_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (i_Enable) begin
      if (i_Return) begin
        if (!empty) begin
          pc_d    = top;
          level_d = level_q - LW'(1);
          for (int i = 0; i < STACK_DEPTH; i++) begin
            if (level_q == LW'(i + 1)) stack_d[i] = '0;
          end
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (i_Call) begin
        if (!full) begin
          for (int i = 0; i < STACK_DEPTH; i++) begin
            if (level_q == LW'(i)) stack_d[i] = pc_inc;
          end
          pc_d    = i_Direccion_salto;
          level_d = level_q + LW'(1);
        end else begin
          pc_d  = pc_inc;
          ovf_d = 1'b1;
        end
      end else if (i_Senal_de_salto) begin
        pc_d = i_Direccion_salto;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge i_Timming or posedge i_Rst) begin
    if (i_Rst) begin
      pc_q    <= RESET_VECTOR;
      stack_q <= '{default: '0};
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      stack_q <= stack_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign o_Fetch       = pc_q;
  assign o_Stack       = top;
  assign o_Stack_Nivel = level_q;
  assign o_Overflow    = ovf_q;
  assign o_Underflow   = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed plan steps plus randomized traffic, checked against a queue-based model.
module tb_pc_call_stack;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
  logic [ADDR_W-1:0] tgt = '0;
  logic [ADDR_W-1:0] fetch, stk;
  logic [2:0]        lvl;
  logic              ovf, unf;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_pc;
  int m_q[$];
  bit m_ovf, m_unf;

  pc_call_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (DEPTH),
    .RESET_VECTOR(8'h00)
  ) dut (
    .i_Timming        (clk),
    .i_Rst            (rst),
    .i_Enable         (en),
    .i_Senal_de_salto (jmp),
    .i_Direccion_salto(tgt),
    .i_Call           (call),
    .i_Return         (ret),
    .o_Fetch          (fetch),
    .o_Stack          (stk),
    .o_Stack_Nivel    (lvl),
    .o_Overflow       (ovf),
    .o_Underflow      (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input bit e, input bit j, input bit c, input bit r, input int t);
    if (!e) return;
    if (r) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_pc = (m_pc + 1) & MASK; m_unf = 1; end
    end else if (c) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back((m_pc + 1) & MASK);
        m_pc = t;
      end else begin
        m_pc = (m_pc + 1) & MASK;
        m_ovf = 1;
      end
    end else if (j) m_pc = t;
    else m_pc = (m_pc + 1) & MASK;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fetch"}, int'(fetch), m_pc);
    chk({tag, ".stack"}, int'(stk), (m_q.size() > 0) ? m_q[$] : 0);
    chk({tag, ".level"}, int'(lvl), m_q.size());
    chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
    chk({tag, ".unf"}, int'(unf), int'(m_unf));
  endtask

  // One clock: drive request, let the edge happen, update model, compare.
  task automatic step(input bit e, input bit j, input bit c, input bit r, input int t,
                      input string tag);
    en = e; jmp = j; call = c; ret = r; tgt = ADDR_W'(t);
    @(posedge clk);
    model_step(e, j, c, r, t);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();
    chk("reset.fetch0", int'(fetch), 0);

    // Sequential increment.
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, 0, 0, "inc");
      chk("inc.fetch", int'(fetch), i);
    end

    // Absolute jump.
    step(1, 1, 0, 0, 'h04, "jmp04");
    step(1, 1, 0, 0, 'h1F, "jmp1f");
    chk("jmp.fetch", int'(fetch), 'h1F);
    step(1, 0, 0, 0, 0, "idle1");
    chk("jmp.idle1", int'(fetch), 'h20);
    step(1, 0, 0, 0, 0, "idle2");
    chk("jmp.idle2", int'(fetch), 'h21);
    chk("jmp.level", int'(lvl), 0);

    // Nested calls and returns.
    step(1, 1, 0, 0, 'h10, "to10");
    step(1, 0, 1, 0, 'h40, "call40");
    chk("call40.fetch", int'(fetch), 'h40);
    chk("call40.level", int'(lvl), 1);
    step(1, 0, 1, 0, 'h80, "call80");
    chk("call80.fetch", int'(fetch), 'h80);
    chk("call80.stack", int'(stk), 'h41);
    chk("call80.level", int'(lvl), 2);
    step(1, 0, 0, 1, 0, "ret1");
    chk("ret1.fetch", int'(fetch), 'h41);
    chk("ret1.level", int'(lvl), 1);
    step(1, 0, 0, 1, 0, "ret2");
    chk("ret2.fetch", int'(fetch), 'h11);
    chk("ret2.level", int'(lvl), 0);
    chk("ret2.stack", int'(stk), 0);

    // Overflow: fifth call is refused.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 'h50, "ovfcall");
    chk("ovf.level", int'(lvl), 4);
    chk("ovf.flag", int'(ovf), 1);
    chk("ovf.fetch", int'(fetch), 'h51);
    step(1, 0, 0, 1, 0, "ovfret");
    chk("ovfret.fetch", int'(fetch), 'h51);
    chk("ovfret.flag", int'(ovf), 1);

    // Underflow and wrap, then stall.
    do_reset();
    step(1, 1, 0, 0, 'hFE, "toFE");
    step(1, 0, 0, 1, 0, "unfret");
    chk("unf.fetch", int'(fetch), 'hFF);
    chk("unf.flag", int'(unf), 1);
    step(1, 0, 0, 0, 0, "wrap");
    chk("wrap.fetch", int'(fetch), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, 'h33, "stall");
      chk("stall.fetch", int'(fetch), 0);
    end

    // Priority with level 1: return wins over call and jump.
    step(1, 0, 1, 0, 'h30, "prcall");
    step(1, 1, 1, 1, 'h77, "prio");
    chk("prio.fetch", int'(fetch), 'h01);
    chk("prio.level", int'(lvl), 0);

    // Asynchronous reset between edges.
    step(1, 0, 1, 0, 'h60, "prerst");
    step(1, 1, 0, 0, 'hC0, "prerst2");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("asyncrst");
    #1;
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, MASK)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
